sram_port_arbiter: RTL and testbench

- Shares the single IHP_SRAM_1024x32 macro between two requesters.
  - Port 0: SAP-3 CPU memory bus (MAR / RAM-write path).
  - Port 1: host loader / debug path that preloads and inspects program memory.
- Arbitrates requests and sequences one SRAM command per transaction.
- Captures the 1-cycle-latency read data and returns an ack pulse to the winning requester.
- Sits between the CPU/loader glue and the SRAM wrapper. It is the only driver of the SRAM control pins.

---
 rtl/sram_port_arbiter.sv | 111 +++++++++++
 tb/tb_sram_port_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: two-port arbiter sequencing one SRAM command per transaction.
// Requests are sampled only in IDLE; every output is decoded from registered state.
module sram_port_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int RR     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W/8-1:0] p0_be,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W/8-1:0] p1_be,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_bm,
    output logic [DATA_W-1:0] sram_din,
    output logic              sram_wen,
    output logic              sram_ren,
    output logic              sram_men,
    input  logic [DATA_W-1:0] sram_dout,
    output logic              busy,
    output logic              grant
);
    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, CMD, WAIT, RESP} state_t;

    state_t              r_state, w_next;
    logic                r_we, r_grant, r_last_grant;
    logic [ADDR_W-1:0]   r_addr;
    logic [BE_W-1:0]     r_be;
    logic [DATA_W-1:0]   r_wdata, r_p0_rdata, r_p1_rdata, w_mask;
    logic                w_any, w_pick;

    always_comb begin
        w_any  = p0_req | p1_req;
        w_pick = (p0_req && p1_req) ? ((RR != 0) ? ~r_last_grant : 1'b0) : p1_req;
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_any ? CMD : IDLE;
            CMD:     w_next = WAIT;
            WAIT:    w_next = RESP;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // last_grant resets to 1 so port 0 wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_be         <= '0;
            r_wdata      <= '0;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (r_state == IDLE && w_any) begin
            r_we         <= w_pick ? p1_we : p0_we;
            r_addr       <= w_pick ? p1_addr : p0_addr;
            r_be         <= w_pick ? p1_be : p0_be;
            r_wdata      <= w_pick ? p1_wdata : p0_wdata;
            r_grant      <= w_pick;
            r_last_grant <= w_pick;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p0_rdata <= '0;
            r_p1_rdata <= '0;
        end else if (r_state == WAIT && !r_we) begin
            if (r_grant)
                r_p1_rdata <= sram_dout;
            else
                r_p0_rdata <= sram_dout;
        end
    end

    for (genvar g = 0; g < BE_W; g++) begin : g_mask
        assign w_mask[8*g +: 8] = {8{r_be[g]}};
    end

    assign sram_men  = (r_state == CMD);
    assign sram_wen  = sram_men & r_we;
    assign sram_ren  = sram_men & ~r_we;
    assign sram_bm   = sram_wen ? w_mask : '0;
    assign sram_addr = r_addr;
    assign sram_din  = r_wdata;
    assign p0_ack    = (r_state == RESP) & ~r_grant;
    assign p1_ack    = (r_state == RESP) & r_grant;
    assign p0_rdata  = r_p0_rdata;
    assign p1_rdata  = r_p1_rdata;
    assign busy      = (r_state != IDLE);
    assign grant     = r_grant;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: randomized bench with a behavioural SRAM and a reference memory.
// Instance u0 uses round-robin arbitration, u1 uses fixed priority.
module tb_sram_port_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
    logic [9:0]  p0_addr = 0, p1_addr = 0;
    logic [3:0]  p0_be = 0, p1_be = 0;
    logic [31:0] p0_wdata = 0, p1_wdata = 0;
    logic        p0_ack, p1_ack, sram_wen, sram_ren, sram_men, busy, grant;
    logic [31:0] p0_rdata, p1_rdata, sram_bm, sram_din, sram_dout;
    logic [9:0]  sram_addr;

    logic        f0_req = 0, f1_req = 0;
    logic [9:0]  f0_addr = 0, f1_addr = 0;
    logic        f0_ack, f1_ack, fs_wen, fs_ren, fs_men, f_busy, f_grant;
    logic [31:0] f0_rdata, f1_rdata, fs_bm, fs_din, fs_dout;
    logic [9:0]  fs_addr;

    sram_port_arbiter #(.ADDR_W(10), .DATA_W(32), .RR(1)) u0 (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_be(p0_be), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_be(p1_be), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .sram_addr(sram_addr), .sram_bm(sram_bm), .sram_din(sram_din), .sram_wen(sram_wen),
        .sram_ren(sram_ren), .sram_men(sram_men), .sram_dout(sram_dout), .busy(busy), .grant(grant)
    );

    sram_port_arbiter #(.ADDR_W(10), .DATA_W(32), .RR(0)) u1 (
        .clk(clk), .rst_n(rst_n),
        .p0_req(f0_req), .p0_we(1'b0), .p0_addr(f0_addr), .p0_be(4'h0), .p0_wdata(32'h0),
        .p0_ack(f0_ack), .p0_rdata(f0_rdata),
        .p1_req(f1_req), .p1_we(1'b0), .p1_addr(f1_addr), .p1_be(4'h0), .p1_wdata(32'h0),
        .p1_ack(f1_ack), .p1_rdata(f1_rdata),
        .sram_addr(fs_addr), .sram_bm(fs_bm), .sram_din(fs_din), .sram_wen(fs_wen),
        .sram_ren(fs_ren), .sram_men(fs_men), .sram_dout(fs_dout), .busy(f_busy), .grant(f_grant)
    );

    // Behavioural SRAM macros: bit-masked write, one-cycle read latency
    logic [31:0] mem0 [1024];
    logic [31:0] mem1 [1024];
    logic        mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 1024; i++) begin
                mem0[i] <= 32'h0;
                mem1[i] <= 32'hA5A50000 ^ i;
            end
            mem_ready <= 1'b1;
        end else begin
            if (sram_men && sram_wen) mem0[sram_addr] <= (mem0[sram_addr] & ~sram_bm) | (sram_din & sram_bm);
            if (sram_men && sram_ren) sram_dout <= mem0[sram_addr];
            if (fs_men && fs_wen) mem1[fs_addr] <= (mem1[fs_addr] & ~fs_bm) | (fs_din & fs_bm);
            if (fs_men && fs_ren) fs_dout <= mem1[fs_addr];
        end
    end

    logic [31:0] ref_mem [1024];
    logic [31:0] exp_rd [2];
    bit          m_last;
    int          checks = 0;
    int          errors = 0;

    task automatic wait_idle();
        int g = 0;
        while (busy && g < 10) begin
            @(posedge clk); #1; g++;
        end
    endtask

    task automatic txn(input bit p, input bit we, input logic [9:0] a, input logic [3:0] be, input logic [31:0] wd);
        int cyc = 0, cmd_cyc = 0;
        bit got = 0, other = 0;
        logic cw = 0, cr = 0;
        logic [9:0] ca = 0;
        logic [31:0] cb = 0, expbm;
        wait_idle();
        if (p) begin
            p1_we = we; p1_addr = a; p1_be = be; p1_wdata = wd; p1_req = 1;
        end else begin
            p0_we = we; p0_addr = a; p0_be = be; p0_wdata = wd; p0_req = 1;
        end
        while (!got && cyc < 12) begin
            @(posedge clk); #1; cyc++;
            if (sram_men && cmd_cyc == 0) begin
                cmd_cyc = cyc; cw = sram_wen; cr = sram_ren; ca = sram_addr; cb = sram_bm;
            end
            if (p ? p0_ack : p1_ack) other = 1;
            got = p ? p1_ack : p0_ack;
        end
        p0_req = 0; p1_req = 0;
        for (int b = 0; b < 4; b++) begin
            expbm[8*b +: 8] = (we && be[b]) ? 8'hFF : 8'h00;
            if (we && be[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
        end
        if (!we) exp_rd[p] = ref_mem[a];
        m_last = p;
        checks++; if (!got) begin errors++; $display("FAIL txn_ack_timeout p%0d a=%h", p, a); end
        checks++; if (cyc != 3) begin errors++; $display("FAIL txn_latency p%0d got %0d want 3", p, cyc); end
        checks++; if (cmd_cyc != 1) begin errors++; $display("FAIL txn_cmd_cycle p%0d got %0d want 1", p, cmd_cyc); end
        checks++; if ({cw, cr} !== {we, ~we}) begin errors++; $display("FAIL txn_wen_ren p%0d got %b want %b", p, {cw, cr}, {we, ~we}); end
        checks++; if (ca !== a) begin errors++; $display("FAIL txn_addr p%0d got %h want %h", p, ca, a); end
        checks++; if (cb !== expbm) begin errors++; $display("FAIL txn_bm p%0d got %h want %h", p, cb, expbm); end
        checks++; if (other) begin errors++; $display("FAIL txn_other_ack p%0d got 1 want 0", p); end
        checks++; if (grant !== p) begin errors++; $display("FAIL txn_grant got %b want %b", grant, p); end
        checks++; if ((p ? p1_rdata : p0_rdata) !== exp_rd[p]) begin
            errors++; $display("FAIL txn_rdata p%0d a=%h got %h want %h", p, a, p ? p1_rdata : p0_rdata, exp_rd[p]);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++; if ({sram_men, sram_wen, sram_ren, busy, grant, p0_ack, p1_ack} !== 7'b0) begin
            errors++; $display("FAIL reset_ctrl got %b want 0", {sram_men, sram_wen, sram_ren, busy, grant, p0_ack, p1_ack});
        end
        checks++; if ({sram_addr, sram_bm, sram_din} !== '0) begin errors++; $display("FAIL reset_sram_bus got %h want 0", {sram_addr, sram_bm, sram_din}); end
        checks++; if ({p0_rdata, p1_rdata} !== 64'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", {p0_rdata, p1_rdata}); end
        repeat (3) @(posedge clk);
        #3 rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        txn(0, 1, 10'h005, 4'hF, 32'hDEADBEEF);
        txn(0, 0, 10'h005, 4'h0, 32'h0);
    endtask

    task automatic test_partial();
        txn(0, 1, 10'h010, 4'hF, 32'h11223344);
        txn(1, 1, 10'h010, 4'b0001, 32'h000000AA);
        txn(1, 0, 10'h010, 4'h0, 32'h0);
        txn(0, 1, 10'h010, 4'h0, 32'hFFFFFFFF);
        txn(0, 0, 10'h010, 4'h0, 32'h0);
    endtask

    task automatic test_wrap();
        txn(0, 1, 10'h3FF, 4'hF, 32'hCAFEF00D);
        txn(1, 1, 10'h000, 4'hF, 32'h01234567);
        txn(0, 0, 10'h3FF, 4'h0, 32'h0);
        txn(1, 0, 10'h000, 4'h0, 32'h0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] v1 = $urandom, v2 = $urandom;
        int cyc = 0, t1 = -1, t2 = -1;
        bit hold_ok = 1;
        txn(1, 1, 10'h001, 4'hF, v1);
        txn(1, 1, 10'h002, 4'hF, v2);
        wait_idle();
        p0_we = 0; p0_addr = 10'h001; p0_req = 1;
        while (t2 < 0 && cyc < 20) begin
            @(posedge clk); #1; cyc++;
            if (p0_ack && t1 < 0) begin
                t1 = cyc;
                checks++; if (p0_rdata !== v1) begin errors++; $display("FAIL b2b_first got %h want %h", p0_rdata, v1); end
                p0_addr = 10'h002;
            end else if (p0_ack) begin
                t2 = cyc;
            end else if (t1 >= 0 && p0_rdata !== v1) begin
                hold_ok = 0;
            end
        end
        p0_req = 0;
        exp_rd[0] = v2; m_last = 0;
        checks++; if (t2 - t1 != 4 || t1 < 0) begin errors++; $display("FAIL b2b_spacing got t1=%0d t2=%0d want 4 apart", t1, t2); end
        checks++; if (!hold_ok) begin errors++; $display("FAIL b2b_hold got changed want %h held", v1); end
        checks++; if (p0_rdata !== v2) begin errors++; $display("FAIL b2b_second got %h want %h", p0_rdata, v2); end
    endtask

    task automatic test_fairness();
        logic [9:0] cur [2];
        int cyc = 0, n = 0, last = 0, p;
        bit want;
        wait_idle();
        want = ~m_last;
        cur[0] = 10'($urandom_range(0, 15)); cur[1] = 10'($urandom_range(0, 15));
        p0_we = 0; p1_we = 0; p0_addr = cur[0]; p1_addr = cur[1];
        p0_req = 1; p1_req = 1;
        while (n < 8 && cyc < 60) begin
            @(posedge clk); #1; cyc++;
            if (p0_ack || p1_ack) begin
                p = int'(p1_ack);
                checks++; if (p0_ack && p1_ack) begin errors++; $display("FAIL rr_both_ack got 11 want one-hot"); end
                checks++; if (p1_ack !== want) begin errors++; $display("FAIL rr_order n=%0d got port %0d want %0d", n, p, want); end
                checks++; if (grant !== p1_ack) begin errors++; $display("FAIL rr_grant got %b want %b", grant, p1_ack); end
                checks++; if ((p1_ack ? p1_rdata : p0_rdata) !== ref_mem[cur[p]]) begin
                    errors++; $display("FAIL rr_rdata port %0d got %h want %h", p, p1_ack ? p1_rdata : p0_rdata, ref_mem[cur[p]]);
                end
                checks++; if (cyc - last != (n == 0 ? 3 : 4)) begin errors++; $display("FAIL rr_spacing n=%0d got %0d", n, cyc - last); end
                exp_rd[p] = ref_mem[cur[p]];
                m_last = p1_ack; want = ~p1_ack; last = cyc; n++;
                cur[p] = 10'($urandom_range(0, 15));
                if (p == 1) p1_addr = cur[1]; else p0_addr = cur[0];
            end
        end
        p0_req = 0; p1_req = 0;
        checks++; if (n != 8) begin errors++; $display("FAIL rr_count got %0d want 8", n); end
    endtask

    task automatic test_fixed_priority();
        int cyc = 0, n = 0;
        bit bad = 0, got1 = 0;
        f0_addr = 10'h033; f1_addr = 10'h044;
        f0_req = 1; f1_req = 1;
        while (n < 8 && cyc < 60) begin
            @(posedge clk); #1; cyc++;
            if (f1_ack || (f_busy && f_grant)) bad = 1;
            if (f0_ack) begin
                n++;
                checks++; if (f0_rdata !== (32'hA5A50000 ^ 32'h033)) begin errors++; $display("FAIL fp_rdata got %h want %h", f0_rdata, 32'hA5A50000 ^ 32'h033); end
            end
        end
        f0_req = 0;
        checks++; if (bad || n != 8) begin errors++; $display("FAIL fp_port1_starve got bad=%0d n=%0d want bad=0 n=8", bad, n); end
        cyc = 0;
        while (!got1 && cyc < 12) begin
            @(posedge clk); #1; cyc++;
            got1 = f1_ack;
        end
        f1_req = 0;
        checks++; if (!got1 || f1_rdata !== (32'hA5A50000 ^ 32'h044)) begin
            errors++; $display("FAIL fp_port1_serve got ack=%0d data=%h want %h", got1, f1_rdata, 32'hA5A50000 ^ 32'h044);
        end
    endtask

    task automatic test_random();
        logic [9:0] a;
        for (int i = 0; i < 24; i++) begin
            a = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(1016, 1023)) : 10'($urandom_range(0, 15));
            txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, 4'($urandom), $urandom);
        end
    endtask

    task automatic test_reset_mid();
        bit acked = 0, got = 0;
        int cyc = 0;
        wait_idle();
        p1_we = 1; p1_addr = 10'h200; p1_be = 4'hF; p1_wdata = 32'h55AA55AA; p1_req = 1;
        @(posedge clk); #1;
        checks++; if (sram_men !== 1'b1 || sram_wen !== 1'b1) begin errors++; $display("FAIL rst_mid_cmd got men=%b wen=%b want 1 1", sram_men, sram_wen); end
        #2 rst_n = 0;
        #1;
        checks++; if ({sram_men, sram_wen, sram_ren, busy} !== 4'b0) begin
            errors++; $display("FAIL rst_mid_ctrl got %b want 0000", {sram_men, sram_wen, sram_ren, busy});
        end
        p1_req = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1; acked |= p1_ack;
        end
        #2 rst_n = 1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1; acked |= p1_ack;
        end
        checks++; if (acked) begin errors++; $display("FAIL rst_mid_noack got 1 want 0"); end
        checks++; if ({p0_rdata, p1_rdata} !== 64'h0) begin errors++; $display("FAIL rst_mid_rdata got %h want 0", {p0_rdata, p1_rdata}); end
        exp_rd[0] = 0; exp_rd[1] = 0; m_last = 1;
        p0_we = 0; p0_addr = 10'h005; p1_we = 0; p1_addr = 10'h010;
        p0_req = 1; p1_req = 1;
        while (!got && cyc < 12) begin
            @(posedge clk); #1; cyc++;
            got = p0_ack | p1_ack;
        end
        checks++; if (!got || !p0_ack || p1_ack) begin errors++; $display("FAIL rst_first_tie got p0=%b p1=%b want p0 wins", p0_ack, p1_ack); end
        checks++; if (p0_rdata !== ref_mem[10'h005]) begin errors++; $display("FAIL rst_tie_rdata got %h want %h", p0_rdata, ref_mem[10'h005]); end
        p0_req = 0; p1_req = 0;
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
        exp_rd[0] = 0; exp_rd[1] = 0; m_last = 1;
        test_reset();
        test_basic();
        test_partial();
        test_wrap();
        test_back_to_back();
        test_fairness();
        test_fixed_priority();
        test_random();
        test_fairness();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule
